seq_writeback_64: RTL and testbench



---
 rtl/y86_pkg.sv | 19 +
 rtl/wb_dst_sel.sv | 27 ++
 rtl/seq_writeback_64.sv | 44 ++++
 tb/tb_seq_writeback_64.sv | 104 ++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icode/register constants and the register-file image type
package y86_pkg;
    localparam logic [3:0] IHALT  = 4'd0;
    localparam logic [3:0] INOP   = 4'd1;
    localparam logic [3:0] ICMOV  = 4'd2;
    localparam logic [3:0] IIRMOV = 4'd3;
    localparam logic [3:0] IRMMOV = 4'd4;
    localparam logic [3:0] IMRMOV = 4'd5;
    localparam logic [3:0] IOPQ   = 4'd6;
    localparam logic [3:0] IJXX   = 4'd7;
    localparam logic [3:0] ICALL  = 4'd8;
    localparam logic [3:0] IRET   = 4'd9;
    localparam logic [3:0] IPUSH  = 4'd10;
    localparam logic [3:0] IPOP   = 4'd11;
    localparam logic [3:0] RRSP   = 4'd4;
    localparam logic [3:0] RNONE  = 4'd15;
    localparam int NREG = 15;
    typedef logic [NREG-1:0][63:0] regfile_t;
endpackage

// File: rtl/wb_dst_sel.sv
// wb_dst_sel: maps icode/rA/rB/cnd to the E and M write destinations (RNONE = no write)
module wb_dst_sel
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    input  logic       cnd,
    output logic [3:0] dste,
    output logic [3:0] dstm
);
    always_comb begin
        dste = RNONE;
        dstm = RNONE;
        case (icode)
            ICMOV:              dste = cnd ? rb : RNONE;
            IIRMOV, IOPQ:       dste = rb;
            IMRMOV:             dstm = ra;
            ICALL, IRET, IPUSH: dste = RRSP;
            IPOP: begin
                dste = RRSP;
                dstm = ra;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/seq_writeback_64.sv
// seq_writeback_64: SEQ write-back; merges valE/valM into the register image and registers it
module seq_writeback_64
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        cnd,
    input  regfile_t    Regin,
    output regfile_t    Regout
);
    logic [3:0] dste, dstm;
    regfile_t   nxt;
    logic       unused;

    assign unused = ^{ifun, valA, valB};

    wb_dst_sel u_sel (
        .icode(icode),
        .ra   (rA),
        .rb   (rB),
        .cnd  (cnd),
        .dste (dste),
        .dstm (dstm)
    );

    // RNONE never matches an index 0..14, so it suppresses its write; M is tested first so it wins
    always_comb begin
        nxt = Regin;
        for (int i = 0; i < NREG; i++)
            nxt[i] = (dstm == 4'(i)) ? valM : (dste == 4'(i)) ? valE : Regin[i];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) Regout <= '0;
        else        Regout <= nxt;
endmodule

// File: tb/tb_seq_writeback_64.sv
// tb_seq_writeback_64: directed and random write-back checks against a destination/overlay model
module tb_seq_writeback_64;
    import y86_pkg::*;

    logic        clk = 0;
    logic        rst_n = 1;
    logic [3:0]  icode = 4'd1, ifun = 0, rA = 4'd15, rB = 4'd15;
    logic [63:0] valA = 0, valB = 0, valE = 0, valM = 0;
    logic        cnd = 0;
    regfile_t    Regin, Regout;
    int          n_cmp = 0, n_err = 0;

    seq_writeback_64 dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valA(valA), .valB(valB), .valE(valE), .valM(valM), .cnd(cnd),
        .Regin(Regin), .Regout(Regout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write list from the instruction table, then overlay E then M so M wins on a tie
    function automatic regfile_t model(input regfile_t r, input int ic, input int ra, input int rb,
                                       input logic c, input logic [63:0] ve, input logic [63:0] vm);
        int de = 15, dm = 15;
        regfile_t res = r;
        if (ic == 2 && c) de = rb;
        if (ic == 3 || ic == 6) de = rb;
        if (ic >= 8 && ic <= 11) de = 4;
        if (ic == 5 || ic == 11) dm = ra;
        if (de != 15) res[de] = ve;
        if (dm != 15) res[dm] = vm;
        return res;
    endfunction

    task automatic init_regs();
        for (int i = 0; i < NREG; i++) Regin[i] = 64'(i);
    endtask

    task automatic check_all(input string tag, input regfile_t exp);
        for (int i = 0; i < NREG; i++) check($sformatf("%s R%0d", tag, i), Regout[i], exp[i]);
    endtask

    task automatic step(input string tag, input int ic, input int ra, input int rb, input logic c,
                        input logic [63:0] ve, input logic [63:0] vm);
        regfile_t exp;
        icode = 4'(ic); ifun = 4'($urandom); rA = 4'(ra); rB = 4'(rb); cnd = c;
        valE = ve; valM = vm; valA = {$urandom, $urandom}; valB = {$urandom, $urandom};
        exp = model(Regin, ic, ra, rb, c, ve, vm);
        @(posedge clk); #1;
        check_all(tag, exp);
        Regin = Regout;
    endtask

    task automatic zero_check(input string tag);
        regfile_t z = '0;
        check_all(tag, z);
    endtask

    initial begin
        init_regs();
        #1 rst_n = 0;
        #1 zero_check("rst_async");
        @(posedge clk); #1 zero_check("rst_held");
        rst_n = 1;
        step("nop_after_rst", 1, 15, 15, 0, 64'd99, 64'd98);
        step("mrmovq", 5, 3, 9, 0, 64'd50, 64'd49);
        step("cmov_t", 2, 4, 10, 1, 64'd51, 64'd7);
        init_regs();
        step("cmov_f", 2, 4, 10, 0, 64'd51, 64'd7);
        step("irmovq", 3, 15, 2, 0, 64'd57, 64'd1);
        step("opq", 6, 1, 9, 0, 64'd50, 64'd1);
        step("call", 8, 2, 7, 0, 64'd76, 64'd1);
        step("ret", 9, 3, 8, 1, 64'd76, 64'd2);
        step("pushq", 10, 5, 6, 0, 64'd76, 64'd3);
        init_regs();
        step("popq", 11, 3, 15, 0, 64'd50, 64'd40);
        step("popq_rsp", 11, 4, 15, 0, 64'd50, 64'd40);
        step("halt", 0, 1, 2, 1, {$urandom, $urandom}, {$urandom, $urandom});
        step("nop", 1, 3, 4, 1, {$urandom, $urandom}, {$urandom, $urandom});
        step("rmmovq", 4, 5, 6, 1, {$urandom, $urandom}, {$urandom, $urandom});
        step("jxx", 7, 7, 8, 1, {$urandom, $urandom}, {$urandom, $urandom});
        step("irmov_none", 3, 0, 15, 0, 64'd57, 64'd5);
        // Reset between edges must clear at once and drop the write set up for the next edge
        icode = 4'd3; rB = 4'd2; valE = 64'd123;
        #3 rst_n = 0;
        #1 zero_check("rst_mid");
        @(posedge clk); #1 zero_check("rst_mid_edge");
        rst_n = 1;
        init_regs();
        for (int n = 0; n < 300; n++)
            step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
